// File: rtl/servo_duty_ramp_if.sv
// Command handshake between a duty-target producer and servo_duty_ramp.
interface servo_duty_ramp_if;
    logic [6:0] target;
    logic       target_valid;
    logic       target_ready;

    modport master (output target, output target_valid, input  target_ready);
    modport slave  (input  target, input  target_valid, output target_ready);
endinterface

// File: rtl/servo_duty_ramp.sv
// Slew-limited duty command stage feeding the servo PWM serializer.
// Optional feature macro: SERVO_RAMP_EN (per-frame STEP limiting); undefined = jump to goal.
module servo_duty_ramp #(
    parameter int unsigned FRAME_CYCLES = 2000000,
    parameter int unsigned STEP         = 2,
    parameter int unsigned DUTY_MAX     = 99,
    parameter int unsigned INIT_DUTY    = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    servo_duty_ramp_if.slave   cmd,
    output logic [6:0]         duty_cycle,
    output logic               frame_tick,
    output logic               settled
);
    localparam int unsigned      CW       = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [6:0]       DMAX     = 7'(DUTY_MAX);
    localparam logic [6:0]       INIT     = 7'(INIT_DUTY);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [6:0]    pend, goal, goal_nxt, duty_nxt, tgt_clamped;
    logic          pend_vld, wrap, accept;

    assign wrap             = (cnt == CNT_LAST);
    assign accept           = cmd.target_valid && !pend_vld;
    assign cmd.target_ready = !pend_vld;
    assign tgt_clamped      = (cmd.target > DMAX) ? DMAX : cmd.target;
    assign settled          = (state == IDLE);

`ifdef SERVO_RAMP_EN
    logic [7:0] d8, g8, diff, stp;
    logic       up;

    // Compare first so the unsigned difference can never wrap.
    always_comb begin
        d8       = {1'b0, duty_cycle};
        g8       = {1'b0, goal_nxt};
        up       = (g8 > d8);
        diff     = up ? (g8 - d8) : (d8 - g8);
        stp      = (diff < 8'(STEP)) ? diff : 8'(STEP);
        duty_nxt = 7'(up ? (d8 + stp) : (d8 - stp));
    end
`else
    assign duty_nxt = goal_nxt;
`endif

    // A pending command becomes the goal on the wrap edge that consumes it.
    always_comb begin
        goal_nxt  = pend_vld ? pend : goal;
        state_nxt = IDLE;
        if (goal_nxt > duty_nxt)      state_nxt = RAMP_UP;
        else if (goal_nxt < duty_nxt) state_nxt = RAMP_DOWN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            goal       <= INIT;
            duty_cycle <= INIT;
            state      <= IDLE;
        end else begin
            cnt        <= wrap ? '0 : cnt + 1'b1;
            frame_tick <= wrap;
            // Accept and consume are exclusive: accept needs an empty slot.
            if (accept) begin
                pend     <= tgt_clamped;
                pend_vld <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end
            if (wrap) begin
                goal       <= goal_nxt;
                duty_cycle <= duty_nxt;
                state      <= state_nxt;
            end
        end
    end
endmodule

// File: tb/tb_servo_duty_ramp.sv
// Directed bench for servo_duty_ramp (FRAME_CYCLES=10, STEP=2); expectations follow SERVO_RAMP_EN.
module tb_servo_duty_ramp;
`ifdef SERVO_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] duty_cycle;
    logic       frame_tick, settled;
    int         cyc, n_vec, n_err;

    servo_duty_ramp_if bus ();

    servo_duty_ramp #(.FRAME_CYCLES(10), .STEP(2), .DUTY_MAX(99), .INIT_DUTY(0)) dut (
        .clk(clk), .reset_n(reset_n), .cmd(bus),
        .duty_cycle(duty_cycle), .frame_tick(frame_tick), .settled(settled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        n_vec++;
        assert (obs === 32'(expv)) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input int d, input int t, input int r, input int s);
        chk({tag, ".duty"},    32'(duty_cycle),       d);
        chk({tag, ".tick"},    32'(frame_tick),       t);
        chk({tag, ".ready"},   32'(bus.target_ready), r);
        chk({tag, ".settled"}, 32'(settled),          s);
    endtask

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic send(input int c, input int v);
        go(c);
        bus.target = 7'(v);
        bus.target_valid = 1'b1;
        chk("send.ready", 32'(bus.target_ready), 1);
        go(c + 1);
        bus.target_valid = 1'b0;
        chk("send.ready_drop", 32'(bus.target_ready), 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        reset_n = 1'b0; bus.target = '0; bus.target_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 1, 1);
        reset_n = 1'b1;
        cyc = 0;

        // Idle frames: tick only at 10, 20, 30.
        for (int c = 1; c <= 30; c++) begin
            go(c);
            chk("idle.tick", 32'(frame_tick), (c % 10 == 0) ? 1 : 0);
        end
        chk_all("idle30", 0, 1, 1, 1);

        // Ramp up to 10.
        send(33, 10);
        go(39); chk_all("up39", 0, 0, 0, 1);
        go(40); chk_all("up40", RAMP ? 2 : 10, 1, 1, RAMP ? 0 : 1);
        go(41); chk("up41.tick", 32'(frame_tick), 0);
        go(50); chk_all("up50", RAMP ? 4 : 10, 1, 1, RAMP ? 0 : 1);
        go(60); chk_all("up60", RAMP ? 6 : 10, 1, 1, RAMP ? 0 : 1);
        go(70); chk_all("up70", RAMP ? 8 : 10, 1, 1, RAMP ? 0 : 1);
        go(80); chk_all("up80", 10, 1, 1, 1);

        // Ramp down to 5, last step is 1.
        send(82, 5);
        go(90);  chk_all("dn90",  RAMP ? 8 : 5, 1, 1, RAMP ? 0 : 1);
        go(100); chk_all("dn100", RAMP ? 6 : 5, 1, 1, RAMP ? 0 : 1);
        go(110); chk_all("dn110", 5, 1, 1, 1);

        // Back-to-back 20 then 4 with valid held: reversal.
        go(112);
        bus.target = 7'd20; bus.target_valid = 1'b1;
        chk("b2b.ready112", 32'(bus.target_ready), 1);
        go(113);
        bus.target = 7'd4;
        chk("b2b.ready113", 32'(bus.target_ready), 0);
        go(119); chk_all("b2b119", 5, 0, 0, 1);
        go(120); chk_all("b2b120", RAMP ? 7 : 20, 1, 1, RAMP ? 0 : 1);
        go(121);
        bus.target_valid = 1'b0;
        chk("b2b.ready121", 32'(bus.target_ready), 0);
        go(130); chk_all("b2b130", RAMP ? 5 : 4, 1, 1, RAMP ? 0 : 1);
        go(140); chk_all("b2b140", 4, 1, 1, 1);

        // Clamp 120 -> 99, final step of 1, no overshoot.
        send(142, 120);
        go(150); chk_all("clamp150", RAMP ? 6 : 99, 1, 1, RAMP ? 0 : 1);
        go(610); chk_all("clamp610", RAMP ? 98 : 99, 1, 1, RAMP ? 0 : 1);
        go(620); chk_all("clamp620", 99, 1, 1, 1);
        go(630); chk_all("clamp630", 99, 1, 1, 1);

        // Accept on the wrap cycle is held for the following wrap.
        send(639, 50);
        go(640); chk_all("wrapacc640", 99, 1, 0, 1);
        go(650); chk_all("wrapacc650", RAMP ? 97 : 50, 1, 1, RAMP ? 0 : 1);

        // Asynchronous reset mid-ramp with a pending command.
        send(652, 30);
        go(655); chk_all("prerst", RAMP ? 97 : 50, 0, 0, RAMP ? 0 : 1);
        #2 reset_n = 1'b0;
        #1 chk_all("asyncrst", 0, 0, 1, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        send(2, 50);
        go(9);  chk_all("post9", 0, 0, 0, 1);
        go(10); chk_all("post10", RAMP ? 2 : 50, 1, 1, RAMP ? 0 : 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/servo_duty_ramp.md
# servo_duty_ramp

Upstream command stage for the servo PWM serializer: accepts target duty-cycle commands (0–99) over a valid/ready handshake and drives the serializer's 7-bit `duty_cycle` input. The output moves toward the target by at most `STEP` per PWM frame, so the driven servo slews smoothly instead of jumping. Frame boundaries come from an internal counter matched to the serializer's 20 ms window (2,000,000 cycles at 100 MHz).

## Interface
- `FRAME_CYCLES`, 2000000, clock cycles per PWM frame; valid range ≥ 2.
- `STEP`, 2, maximum duty change per frame; valid range 1–99.
- `DUTY_MAX`, 99, upper clamp for targets and duty.
- `INIT_DUTY`, 0, duty and goal value after reset; must be ≤ `DUTY_MAX`.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `target` in 7: requested duty, 0–127; values above `DUTY_MAX` are clamped.
- `target_valid` in 1: `target` is valid this cycle.
- `target_ready` out 1: pending slot is empty.
- `duty_cycle` out 7: registered duty to the serializer.
- `frame_tick` out 1: one-cycle pulse marking each frame boundary.
- `settled` out 1: `duty_cycle` equals the active goal.

## Operation
- **Frame counter:** runs 0..`FRAME_CYCLES`-1 and wraps. On the wrap edge:
  - `frame_tick` is registered to 1 for exactly one cycle.
  - All duty and goal updates occur on this same edge.
- **Pending slot:** one entry.
  - `target_ready` = !`pending_valid`.
  - Accept when `target_valid` && `target_ready`: store min(`target`, `DUTY_MAX`) and set `pending_valid`.
  - No overwrite while the slot is full; the producer holds `target` until ready.
- **On a wrap edge:**
  - If `pending_valid` was set before the edge: goal ← pending and `pending_valid` ← 0.
  - Then `duty_cycle` steps toward the new goal by min(`STEP`, |goal−duty|).
- **Simultaneous tick and accept:** only possible when the slot is empty. The value is stored in pending and consumed at the next wrap, not the current one.
- **Arithmetic:** the difference and step are computed in 8-bit unsigned with the comparison done first. `duty_cycle` never overshoots the goal and never leaves 0..`DUTY_MAX`.
- **State machine** (state register updated on wrap edges only):
  - IDLE: duty == goal. `settled` = 1.
  - RAMP_UP: goal > duty.
  - RAMP_DOWN: goal < duty.
  - Transitions are evaluated after the step is applied. The final step enters IDLE on the same edge.
  - A new goal during a ramp may reverse direction (RAMP_UP ↔ RAMP_DOWN) directly.
- **Reset (any time, including mid-ramp):**
  - `duty_cycle` = `INIT_DUTY`; goal = `INIT_DUTY`; pending cleared; counter = 0.
  - `frame_tick` = 0, `target_ready` = 1, `settled` = 1, state = IDLE.

## Timing
- `duty_cycle`, `frame_tick` and `settled` are registered and change together on the wrap edge.
- After `reset_n` deasserts, the first `frame_tick` is asserted in cycle `FRAME_CYCLES` (counter 0 at reset = cycle 0).
- **Command latency:** a target accepted in any cycle of frame k first affects `duty_cycle` at the end of frame k.
  - Exception: an accept in the tick cycle itself shifts to the next frame end.
- **Ready timing:** `target_ready` drops on the edge after an accept and rises on the wrap edge that empties the slot.
- `settled` is valid in the same cycle as the `duty_cycle` it describes.

## Configuration
- `SERVO_RAMP_EN` defined: slew limiting as described above.
- `SERVO_RAMP_EN` undefined:
  - On each wrap edge, `duty_cycle` ← goal directly and `STEP` is ignored.
  - State is always IDLE and `settled` is 1 after every tick.
  - Handshake, clamp and frame counter are unchanged.

## Test plan
All scenarios use `FRAME_CYCLES`=10, `STEP`=2, `INIT_DUTY`=0, with `SERVO_RAMP_EN` defined unless noted.

1. Reset, then idle for 30 cycles -> `duty_cycle`=0, `settled`=1, `target_ready`=1, `frame_tick` pulses at cycles 10, 20, 30.
2. Accept `target`=10 at cycle 3 -> `duty_cycle` takes 2,4,6,8,10 at ticks 10..50, and `settled` rises with the value 10.
3. Accept `target`=120 -> pending holds 99; `duty_cycle` ramps by 2 and ends exactly at 99 without overshoot.
4. Settle at 10, then accept `target`=5 -> `duty_cycle` takes 8, 6, 5 on successive ticks via RAMP_DOWN.
5. Present `target`=20 and then `target`=4 back-to-back with `target_valid` held -> second command sees `target_ready`=0 until the next tick and is accepted one cycle after it; direction reverses without error.
6. Pull `reset_n` low mid-ramp at duty 6 -> all outputs return to reset values immediately (asynchronously). With `SERVO_RAMP_EN` undefined, `target`=50 -> `duty_cycle`=50 at the first tick.
